// File: rtl/simon_pkg.sv
// Shared widths, AXI response encodings and FSM state type for the Simon
// configuration-port AXI4-Lite master.
package simon_pkg;

  localparam int CFG_ADDR_WIDTH = 16;
  localparam int CFG_DATA_WIDTH = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RESP    = 3'd5
  } axil_mst_state_t;

  // Add 0..2 stray beats to an 8-bit counter, sticking at 255.
  function automatic logic [7:0] sat_add8(input logic [7:0] v, input logic [1:0] n);
    logic [8:0] s;
    s = {1'b0, v} + {7'd0, n};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/simon_cfg_axil_master_if.sv
// AXI4-Lite bus bundle between the configuration master and its slave.
interface simon_cfg_axil_master_if #(
  parameter int ADDR_W = simon_pkg::CFG_ADDR_WIDTH,
  parameter int DATA_W = simon_pkg::CFG_DATA_WIDTH
) ();
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/simon_cfg_timeout_ctr.sv
// Response-wait counter: expired flags the LIMIT-th waiting cycle.
// LIMIT=0 disables expiry entirely.
module simon_cfg_timeout_ctr #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk_simon_cfg,
  input  logic rst_simon_cfg,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int unsigned CW       = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam int unsigned LIMIT_M1 = (LIMIT == 0) ? 0 : LIMIT - 1;

  logic [CW-1:0] cnt_reg;

  assign expired = (LIMIT != 0) && (cnt_reg == CW'(LIMIT_M1));

  // Count waiting cycles; clear wins so each response phase starts at zero.
  always_ff @(posedge clk_simon_cfg) begin
    if (rst_simon_cfg || clr) begin
      cnt_reg <= '0;
    end else if (en && !expired) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end
endmodule

// File: rtl/simon_cfg_axil_master.sv
// Command-port to AXI4-Lite master with independent AW/W handshakes,
// write-verify readback, response timeout and stray-beat counting.
module simon_cfg_axil_master #(
  parameter int          CFG_ADDR_WIDTH = simon_pkg::CFG_ADDR_WIDTH,
  parameter int          CFG_DATA_WIDTH = simon_pkg::CFG_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                        clk_simon_cfg,
  input  logic                        rst_simon_cfg,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic                        cmd_verify,
  input  logic [CFG_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [CFG_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [CFG_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [CFG_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic                        rsp_timeout,
  output logic                        rsp_mismatch,
  output logic [7:0]                  stray_cnt,
  simon_cfg_axil_master_if.master     simon_cfg
);
  import simon_pkg::*;

  localparam int STRB_W = CFG_DATA_WIDTH / 8;

  axil_mst_state_t             state_reg, state_next;
  logic                        awvalid_reg, awvalid_next, wvalid_reg, wvalid_next;
  logic                        arvalid_reg, arvalid_next;
  logic                        bready_reg, bready_next, rready_reg, rready_next;
  logic                        rsp_valid_reg, rsp_valid_next;
  logic [CFG_DATA_WIDTH-1:0]   rsp_rdata_reg, rsp_rdata_next;
  logic [1:0]                  rsp_resp_reg, rsp_resp_next;
  logic                        rsp_timeout_reg, rsp_timeout_next;
  logic                        rsp_mismatch_reg, rsp_mismatch_next;
  logic [CFG_ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [CFG_DATA_WIDTH-1:0]   wdata_reg, wdata_next;
  logic [STRB_W-1:0]           wstrb_reg, wstrb_next;
  logic                        verify_reg, verify_next;
  logic [7:0]                  stray_cnt_reg;
  logic [STRB_W-1:0]           byte_diff;
  logic                        b_hs, r_hs, in_quiet, to_clr, to_en, to_expired;

  assign b_hs     = simon_cfg.bvalid && bready_reg;
  assign r_hs     = simon_cfg.rvalid && rready_reg;
  assign in_quiet = (state_reg == ST_IDLE) || (state_reg == ST_RESP);

  // Readback differs from the written data in some enabled byte lane.
  for (genvar gi = 0; gi < STRB_W; gi++) begin : g_byte_cmp
    assign byte_diff[gi] = wstrb_reg[gi] &&
                           (simon_cfg.rdata[gi*8 +: 8] != wdata_reg[gi*8 +: 8]);
  end

  // Waiting cycles are only counted in the two response phases.
  assign to_clr = ((state_next == ST_WR_RESP) && (state_reg != ST_WR_RESP)) ||
                  ((state_next == ST_RD_DATA) && (state_reg != ST_RD_DATA));
  assign to_en  = ((state_reg == ST_WR_RESP) && !simon_cfg.bvalid) ||
                  ((state_reg == ST_RD_DATA) && !simon_cfg.rvalid);

  simon_cfg_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk_simon_cfg (clk_simon_cfg),
    .rst_simon_cfg (rst_simon_cfg),
    .clr           (to_clr),
    .en            (to_en),
    .expired       (to_expired)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_next        = state_reg;
    awvalid_next      = awvalid_reg;
    wvalid_next       = wvalid_reg;
    arvalid_next      = arvalid_reg;
    rsp_valid_next    = rsp_valid_reg;
    rsp_rdata_next    = rsp_rdata_reg;
    rsp_resp_next     = rsp_resp_reg;
    rsp_timeout_next  = rsp_timeout_reg;
    rsp_mismatch_next = rsp_mismatch_reg;
    addr_next         = addr_reg;
    wdata_next        = wdata_reg;
    wstrb_next        = wstrb_reg;
    verify_next       = verify_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_next   = cmd_addr;
          wdata_next  = cmd_wdata;
          wstrb_next  = cmd_wstrb;
          verify_next = cmd_write && cmd_verify;
          if (cmd_write) begin
            state_next   = ST_WR_REQ;
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
          end else begin
            state_next   = ST_RD_REQ;
            arvalid_next = 1'b1;
          end
        end
      end
      ST_WR_REQ: begin
        if (simon_cfg.awready) awvalid_next = 1'b0;
        if (simon_cfg.wready)  wvalid_next  = 1'b0;
        if ((!awvalid_reg || simon_cfg.awready) && (!wvalid_reg || simon_cfg.wready))
          state_next = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (b_hs) begin
          if (verify_reg && (simon_cfg.bresp == RESP_OKAY)) begin
            state_next   = ST_RD_REQ;
            arvalid_next = 1'b1;
          end else begin
            state_next        = ST_RESP;
            rsp_valid_next    = 1'b1;
            rsp_rdata_next    = '0;
            rsp_resp_next     = simon_cfg.bresp;
            rsp_timeout_next  = 1'b0;
            rsp_mismatch_next = 1'b0;
          end
        end else if (to_expired) begin
          state_next        = ST_RESP;
          rsp_valid_next    = 1'b1;
          rsp_rdata_next    = '0;
          rsp_resp_next     = RESP_SLVERR;
          rsp_timeout_next  = 1'b1;
          rsp_mismatch_next = 1'b0;
        end
      end
      ST_RD_REQ: begin
        if (simon_cfg.arready) begin
          arvalid_next = 1'b0;
          state_next   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (r_hs) begin
          state_next        = ST_RESP;
          rsp_valid_next    = 1'b1;
          rsp_rdata_next    = simon_cfg.rdata;
          rsp_resp_next     = simon_cfg.rresp;
          rsp_timeout_next  = 1'b0;
          rsp_mismatch_next = verify_reg && (|byte_diff);
        end else if (to_expired) begin
          state_next        = ST_RESP;
          rsp_valid_next    = 1'b1;
          rsp_rdata_next    = '0;
          rsp_resp_next     = RESP_SLVERR;
          rsp_timeout_next  = 1'b1;
          rsp_mismatch_next = 1'b0;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // B/R ready stay high in the quiet states so stray beats are drained.
    bready_next = (state_next == ST_IDLE) || (state_next == ST_WR_RESP) || (state_next == ST_RESP);
    rready_next = (state_next == ST_IDLE) || (state_next == ST_RD_DATA) || (state_next == ST_RESP);
  end

  // State, output and latched-command registers.
  always_ff @(posedge clk_simon_cfg) begin
    if (rst_simon_cfg) begin
      state_reg        <= ST_IDLE;
      awvalid_reg      <= 1'b0;
      wvalid_reg       <= 1'b0;
      arvalid_reg      <= 1'b0;
      bready_reg       <= 1'b0;
      rready_reg       <= 1'b0;
      rsp_valid_reg    <= 1'b0;
      rsp_rdata_reg    <= '0;
      rsp_resp_reg     <= '0;
      rsp_timeout_reg  <= 1'b0;
      rsp_mismatch_reg <= 1'b0;
      addr_reg         <= '0;
      wdata_reg        <= '0;
      wstrb_reg        <= '0;
      verify_reg       <= 1'b0;
      stray_cnt_reg    <= '0;
    end else begin
      state_reg        <= state_next;
      awvalid_reg      <= awvalid_next;
      wvalid_reg       <= wvalid_next;
      arvalid_reg      <= arvalid_next;
      bready_reg       <= bready_next;
      rready_reg       <= rready_next;
      rsp_valid_reg    <= rsp_valid_next;
      rsp_rdata_reg    <= rsp_rdata_next;
      rsp_resp_reg     <= rsp_resp_next;
      rsp_timeout_reg  <= rsp_timeout_next;
      rsp_mismatch_reg <= rsp_mismatch_next;
      addr_reg         <= addr_next;
      wdata_reg        <= wdata_next;
      wstrb_reg        <= wstrb_next;
      verify_reg       <= verify_next;
      stray_cnt_reg    <= sat_add8(stray_cnt_reg,
                                   {1'b0, in_quiet && b_hs} + {1'b0, in_quiet && r_hs});
    end
  end

  assign cmd_ready         = (state_reg == ST_IDLE) && !rst_simon_cfg;
  assign rsp_valid         = rsp_valid_reg;
  assign rsp_rdata         = rsp_rdata_reg;
  assign rsp_resp          = rsp_resp_reg;
  assign rsp_timeout       = rsp_timeout_reg;
  assign rsp_mismatch      = rsp_mismatch_reg;
  assign stray_cnt         = stray_cnt_reg;
  assign simon_cfg.awaddr  = addr_reg;
  assign simon_cfg.awprot  = 3'b000;
  assign simon_cfg.awvalid = awvalid_reg;
  assign simon_cfg.wdata   = wdata_reg;
  assign simon_cfg.wstrb   = wstrb_reg;
  assign simon_cfg.wvalid  = wvalid_reg;
  assign simon_cfg.bready  = bready_reg;
  assign simon_cfg.araddr  = addr_reg;
  assign simon_cfg.arprot  = 3'b000;
  assign simon_cfg.arvalid = arvalid_reg;
  assign simon_cfg.rready  = rready_reg;
endmodule

// File: tb/tb_simon_cfg_axil_master.sv
// Directed bench for simon_cfg_axil_master with a configurable AXI-Lite
// slave model and a response scoreboard.
module tb_simon_cfg_axil_master;
  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
    logic        mm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0, cmd_verify = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout, rsp_mismatch;
  logic [7:0]  stray_cnt;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb[$];

  // slave behaviour settings
  int          aw_wait = 0, w_wait = 0, b_wait = 0, r_wait = 0;
  logic        b_en = 1'b1, r_en = 1'b1;
  logic [1:0]  bresp_k = 2'b00, rresp_k = 2'b00;
  logic [31:0] rdata_k = '0;
  int          inj_req = 0, inj_done = 0;
  int          b_hs_cnt = 0, ar_hs_cnt = 0;
  int          aw_cnt = 0, w_cnt = 0, b_left = 0, r_left = 0;
  logic        aw_seen = 1'b0, w_seen = 1'b0, b_arm = 1'b0, r_arm = 1'b0;
  logic        aw_hs, w_hs, ar_hs;

  simon_cfg_axil_master_if #(.ADDR_W(16), .DATA_W(32)) axi ();

  simon_cfg_axil_master #(
    .CFG_ADDR_WIDTH(16), .CFG_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_simon_cfg (clk),
    .rst_simon_cfg (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_verify    (cmd_verify),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_wstrb     (cmd_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .rsp_timeout   (rsp_timeout),
    .rsp_mismatch  (rsp_mismatch),
    .stray_cnt     (stray_cnt),
    .simon_cfg     (axi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave: ready after a programmable number of valid cycles.
  assign axi.awready = axi.awvalid && (aw_cnt >= aw_wait);
  assign axi.wready  = axi.wvalid && (w_cnt >= w_wait);
  assign axi.arready = axi.arvalid;
  assign aw_hs = axi.awvalid && axi.awready;
  assign w_hs  = axi.wvalid && axi.wready;
  assign ar_hs = axi.arvalid && axi.arready;

  always @(posedge clk) begin
    aw_cnt <= (!axi.awvalid || axi.awready) ? 0 : aw_cnt + 1;
    w_cnt  <= (!axi.wvalid || axi.wready) ? 0 : w_cnt + 1;
  end

  // Slave B channel: one response per completed AW+W pair, plus injected strays.
  always @(posedge clk) begin
    if (rst) begin
      aw_seen <= 1'b0; w_seen <= 1'b0; b_arm <= 1'b0; b_left <= 0;
      axi.bvalid <= 1'b0; axi.bresp <= 2'b00;
    end else begin
      if (axi.bvalid && axi.bready) begin
        axi.bvalid <= 1'b0;
        b_hs_cnt   <= b_hs_cnt + 1;
      end
      if ((aw_seen || aw_hs) && (w_seen || w_hs)) begin
        aw_seen <= 1'b0;
        w_seen  <= 1'b0;
        if (b_en) begin
          if (b_wait == 0) begin
            axi.bvalid <= 1'b1; axi.bresp <= bresp_k;
          end else begin
            b_arm <= 1'b1; b_left <= b_wait - 1;
          end
        end
      end else begin
        aw_seen <= aw_seen || aw_hs;
        w_seen  <= w_seen || w_hs;
      end
      if (b_arm) begin
        if (b_left == 0) begin
          axi.bvalid <= 1'b1; axi.bresp <= bresp_k; b_arm <= 1'b0;
        end else begin
          b_left <= b_left - 1;
        end
      end else if (inj_req != inj_done) begin
        axi.bvalid <= 1'b1; axi.bresp <= 2'b00; inj_done <= inj_done + 1;
      end
    end
  end

  // Slave R channel: one beat per AR handshake after r_wait cycles.
  always @(posedge clk) begin
    if (rst) begin
      r_arm <= 1'b0; r_left <= 0;
      axi.rvalid <= 1'b0; axi.rdata <= '0; axi.rresp <= 2'b00;
    end else begin
      if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
      if (ar_hs) begin
        ar_hs_cnt <= ar_hs_cnt + 1;
        if (r_en) begin
          if (r_wait == 0) begin
            axi.rvalid <= 1'b1; axi.rdata <= rdata_k; axi.rresp <= rresp_k;
          end else begin
            r_arm <= 1'b1; r_left <= r_wait - 1;
          end
        end
      end
      if (r_arm) begin
        if (r_left == 0) begin
          axi.rvalid <= 1'b1; axi.rdata <= rdata_k; axi.rresp <= rresp_k; r_arm <= 1'b0;
        end else begin
          r_left <= r_left - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a command at a negedge; returns at the negedge after acceptance.
  task automatic send_cmd(input logic w, input logic v, input logic [15:0] a,
                          input logic [31:0] d, input logic [3:0] s, output int acc);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_verify = v;
    cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 50) begin
      @(negedge clk); n++;
    end
    chk("cmd_accept", cmd_ready, 1);
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    $display("cmd  cyc=%0d write=%0b verify=%0b addr=%h wdata=%h strb=%h", acc, w, v, a, d, s);
  endtask

  // Wait for a response, optionally stall it, then compare with the scoreboard.
  task automatic get_rsp(input string tag, input int hold, output int rcyc);
    int   n = 0;
    exp_t e, snap;
    while (!rsp_valid && n < 200) begin
      @(negedge clk); n++;
    end
    rcyc = cyc;
    chk($sformatf("%s rsp_seen", tag), rsp_valid, 1);
    chk($sformatf("%s cmd_ready_busy", tag), cmd_ready, 0);
    snap = '{rsp_rdata, rsp_resp, rsp_timeout, rsp_mismatch};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk($sformatf("%s hold_valid", tag), rsp_valid, 1);
      chk($sformatf("%s hold_stable", tag),
          {rsp_rdata, rsp_resp, rsp_timeout, rsp_mismatch}, snap);
    end
    rsp_ready = 1'b1;
    chk($sformatf("%s sb_depth", tag), sb.size(), 1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    chk($sformatf("%s rdata", tag), rsp_rdata, e.rdata);
    chk($sformatf("%s resp", tag), rsp_resp, e.resp);
    chk($sformatf("%s timeout", tag), rsp_timeout, e.to);
    chk($sformatf("%s mismatch", tag), rsp_mismatch, e.mm);
    $display("rsp  %s cyc=%0d rdata=%h resp=%0d to=%0b mm=%0b", tag, rcyc,
             rsp_rdata, rsp_resp, rsp_timeout, rsp_mismatch);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk($sformatf("%s rsp_dropped", tag), rsp_valid, 0);
    chk($sformatf("%s cmd_ready_next", tag), cmd_ready, 1);
  endtask

  initial begin
    int acc, rc, base, seen;
    // ---- reset values
    repeat (3) @(negedge clk);
    chk("rst cmd_ready", cmd_ready, 0);
    chk("rst valids", {axi.awvalid, axi.wvalid, axi.arvalid, rsp_valid}, 4'b0000);
    chk("rst readys", {axi.bready, axi.rready}, 2'b00);
    chk("rst rsp fields", {rsp_rdata, rsp_resp, rsp_timeout, rsp_mismatch}, 36'd0);
    chk("rst stray", stray_cnt, 0);
    rst = 1'b0;
    #1;
    chk("post_rst cmd_ready", cmd_ready, 1);
    @(negedge clk);

    // ---- plain write, zero-wait slave
    sb.push_back('{32'h0, 2'b00, 1'b0, 1'b0});
    send_cmd(1'b1, 1'b0, 16'h0004, 32'hDEADBEEF, 4'hF, acc);
    chk("wr aw_w_valid", {axi.awvalid, axi.wvalid, axi.awready, axi.wready}, 4'b1111);
    chk("wr awaddr", axi.awaddr, 16'h0004);
    chk("wr wdata", axi.wdata, 32'hDEADBEEF);
    chk("wr wstrb", axi.wstrb, 4'hF);
    get_rsp("wr", 0, rc);
    chk("wr latency", rc - acc, 3);

    // ---- write with awready delayed 3 cycles
    aw_wait = 3;
    base = b_hs_cnt;
    sb.push_back('{32'h0, 2'b00, 1'b0, 1'b0});
    send_cmd(1'b1, 1'b0, 16'h0008, 32'h01020304, 4'hF, acc);
    chk("awdly N+1", {axi.awvalid, axi.wvalid, axi.wready}, 3'b111);
    @(negedge clk);
    chk("awdly N+2", {axi.awvalid, axi.wvalid}, 2'b10);
    repeat (2) @(negedge clk);
    chk("awdly N+4", {axi.awvalid, axi.awready}, 2'b11);
    @(negedge clk);
    chk("awdly N+5", axi.awvalid, 0);
    get_rsp("awdly", 0, rc);
    chk("awdly latency", rc - acc, 6);
    chk("awdly one_b", b_hs_cnt - base, 1);
    aw_wait = 0;

    // ---- read with 5 wait cycles, response stalled 2 cycles
    r_wait = 5; rdata_k = 32'h12345678; rresp_k = 2'b00;
    sb.push_back('{32'h12345678, 2'b00, 1'b0, 1'b0});
    send_cmd(1'b0, 1'b0, 16'h0008, 32'h0, 4'h0, acc);
    chk("rd araddr", {axi.arvalid, axi.araddr}, {1'b1, 16'h0008});
    get_rsp("rd", 2, rc);
    chk("rd latency", rc - acc, 8);
    r_wait = 0;

    // ---- verify write, masked bytes differ only
    rdata_k = 32'hFFFFA5A5;
    base = ar_hs_cnt;
    sb.push_back('{32'hFFFFA5A5, 2'b00, 1'b0, 1'b0});
    send_cmd(1'b1, 1'b1, 16'h0010, 32'hA5A5A5A5, 4'h3, acc);
    get_rsp("vfy_ok", 0, rc);
    chk("vfy_ok latency", rc - acc, 5);
    chk("vfy_ok one_ar", ar_hs_cnt - base, 1);

    // ---- verify write, enabled byte differs
    rdata_k = 32'h0000A5A4;
    sb.push_back('{32'h0000A5A4, 2'b00, 1'b0, 1'b1});
    send_cmd(1'b1, 1'b1, 16'h0010, 32'hA5A5A5A5, 4'h3, acc);
    get_rsp("vfy_bad", 0, rc);

    // ---- verify write, B returns SLVERR: no readback
    bresp_k = 2'b10;
    base = ar_hs_cnt;
    sb.push_back('{32'h0, 2'b10, 1'b0, 1'b0});
    send_cmd(1'b1, 1'b1, 16'h0010, 32'hA5A5A5A5, 4'h3, acc);
    get_rsp("vfy_slverr", 0, rc);
    chk("vfy_slverr no_ar", ar_hs_cnt - base, 0);
    bresp_k = 2'b00;

    // ---- B never arrives: timeout after 16 cycles in WR_RESP
    b_en = 1'b0;
    sb.push_back('{32'h0, 2'b10, 1'b1, 1'b0});
    send_cmd(1'b1, 1'b0, 16'h0020, 32'h55AA55AA, 4'hF, acc);
    get_rsp("tmo", 0, rc);
    chk("tmo latency", rc - acc, 18);
    b_en = 1'b1;
    inj_req = inj_req + 1;
    repeat (4) @(negedge clk);
    chk("stray bvalid_drained", axi.bvalid, 0);
    chk("stray count", stray_cnt, 1);
    chk("stray no_rsp", rsp_valid, 0);
    $display("stray cyc=%0d stray_cnt=%0d", cyc, stray_cnt);

    // ---- reset while waiting in RD_DATA
    r_en = 1'b0;
    send_cmd(1'b0, 1'b0, 16'h0030, 32'h0, 4'h0, acc);
    @(negedge clk);
    chk("rstmid in_rd_data", {axi.arvalid, axi.rready}, 2'b01);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid outputs", {axi.arvalid, axi.rready, rsp_valid, cmd_ready}, 4'b0000);
    rst = 1'b0;
    #1;
    chk("rstmid cmd_ready", cmd_ready, 1);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("rstmid no_rsp", seen, 0);
    $display("rstmid cyc=%0d cmd_ready=%0b", cyc, cmd_ready);
    r_en = 1'b1;

    chk("sb empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
